// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register index width,
// FSM state encodings and the packed bundle of stage controls.
package hazard_ctrl_pkg;

   localparam int REG_ADDR = 5;

   typedef logic [REG_ADDR-1:0] reg_addr_t;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_MEM_WAIT = 2'd1,
      HZ_HALT     = 2'd2
   } hz_state_e;

   typedef struct packed {
      logic pc_freeze;
      logic if_id_freeze;
      logic if_id_flush;
      logic id_ex_freeze;
      logic id_ex_flush;
      logic ex_mem_freeze;
      logic mem_wb_flush;
      logic halted;
   } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle. The datapath side is the
// master; HAZARD_STATS_EN adds the performance counter outputs.
interface hazard_ctrl_if;
   import hazard_ctrl_pkg::*;

   reg_addr_t id_rs;
   reg_addr_t id_rt;
   logic      id_uses_rs;
   logic      id_uses_rt;
   logic      ex_mem_read;
   reg_addr_t ex_rd;
   logic      ex_redirect;
   logic      mem_req;
   logic      mem_ready;

   logic pc_freeze;
   logic if_id_freeze;
   logic if_id_flush;
   logic id_ex_freeze;
   logic id_ex_flush;
   logic ex_mem_freeze;
   logic mem_wb_flush;
   logic halted;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_events;
   logic [31:0] lu_events;
`endif

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
             ex_redirect, mem_req, mem_ready,
      input  pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush,
             ex_mem_freeze, mem_wb_flush, halted
`ifdef HAZARD_STATS_EN
      , input stall_cycles, flush_events, lu_events
`endif
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
             ex_redirect, mem_req, mem_ready,
      output pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush,
             ex_mem_freeze, mem_wb_flush, halted
`ifdef HAZARD_STATS_EN
      , output stall_cycles, flush_events, lu_events
`endif
   );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. r0 never matches.
module hazard_detect
   import hazard_ctrl_pkg::*;
(
   input  reg_addr_t id_rs,
   input  reg_addr_t id_rt,
   input  logic      id_uses_rs,
   input  logic      id_uses_rt,
   input  logic      ex_mem_read,
   input  reg_addr_t ex_rd,
   output logic      lu
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = id_uses_rs && (id_rs == ex_rd);
   assign rt_hit = id_uses_rt && (id_rt == ex_rd);
   assign lu     = ex_mem_read && (ex_rd != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with watchdog, redirect
// squash and load-use bubble. Optional counters under HAZARD_STATS_EN.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave hz
);

   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

   hz_state_e        state;
   logic [CNT_W-1:0] wait_cnt;
   logic             lu;
   logic             mem_stall;
   logic             lu_take;
   hz_ctrl_t         ctrl;

   hazard_detect u_detect (
      .id_rs       (hz.id_rs),
      .id_rt       (hz.id_rt),
      .id_uses_rs  (hz.id_uses_rs),
      .id_uses_rt  (hz.id_uses_rt),
      .ex_mem_read (hz.ex_mem_read),
      .ex_rd       (hz.ex_rd),
      .lu          (lu)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= HZ_RUN;
         wait_cnt <= '0;
      end else begin
         case (state)
            HZ_RUN: begin
               wait_cnt <= '0;
               if (hz.mem_req && !hz.mem_ready) state <= HZ_MEM_WAIT;
            end
            HZ_MEM_WAIT: begin
               if (hz.mem_ready) begin
                  state <= HZ_RUN;
               end else begin
                  if (wait_cnt == LAST_WAIT) state <= HZ_HALT;
                  if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
               end
            end
            HZ_HALT: state <= HZ_HALT;
            default: state <= HZ_RUN;
         endcase
      end
   end

   // The release cycle (mem_ready=1) is deliberately not a stall.
   assign mem_stall = ((state == HZ_RUN) && hz.mem_req && !hz.mem_ready) ||
                      ((state == HZ_MEM_WAIT) && !hz.mem_ready);
   assign lu_take   = !rst && (state != HZ_HALT) && !mem_stall &&
                      !hz.ex_redirect && lu;

   // NOTE: every field gets a default before the priority chain, so no path
   // through the block can infer a latch.
   always_comb begin
      ctrl = '0;
      if (rst) begin
         ctrl = '0;
      end else if (state == HZ_HALT || mem_stall) begin
         ctrl.pc_freeze     = 1'b1;
         ctrl.if_id_freeze  = 1'b1;
         ctrl.id_ex_freeze  = 1'b1;
         ctrl.ex_mem_freeze = 1'b1;
         ctrl.mem_wb_flush  = 1'b1;
         ctrl.halted        = (state == HZ_HALT);
      end else if (hz.ex_redirect) begin
         ctrl.if_id_flush = 1'b1;
         ctrl.id_ex_flush = 1'b1;
      end else if (lu) begin
         ctrl.pc_freeze    = 1'b1;
         ctrl.if_id_freeze = 1'b1;
         ctrl.id_ex_flush  = 1'b1;
      end
   end

   assign hz.pc_freeze     = ctrl.pc_freeze;
   assign hz.if_id_freeze  = ctrl.if_id_freeze;
   assign hz.if_id_flush   = ctrl.if_id_flush;
   assign hz.id_ex_freeze  = ctrl.id_ex_freeze;
   assign hz.id_ex_flush   = ctrl.id_ex_flush;
   assign hz.ex_mem_freeze = ctrl.ex_mem_freeze;
   assign hz.mem_wb_flush  = ctrl.mem_wb_flush;
   assign hz.halted        = ctrl.halted;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;
   logic [31:0] lu_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
         lu_q    <= '0;
      end else begin
         if (ctrl.pc_freeze)   stall_q <= stall_q + 32'd1;
         if (ctrl.if_id_flush) flush_q <= flush_q + 32'd1;
         if (lu_take)          lu_q    <= lu_q + 32'd1;
      end
   end

   assign hz.stall_cycles = stall_q;
   assign hz.flush_events = flush_q;
   assign hz.lu_events    = lu_q;
`else
   logic unused_lu_take;
   assign unused_lu_take = lu_take;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT=4); also checks the counters
// when built with HAZARD_STATS_EN.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam logic [7:0] IDLE  = 8'b0000_0000;
   localparam logic [7:0] STALL = 8'b1101_0110;
   localparam logic [7:0] HALT  = 8'b1101_0111;
   localparam logic [7:0] RDR   = 8'b0010_1000;
   localparam logic [7:0] LU    = 8'b1100_1000;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   hazard_ctrl_if hz ();

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   always #5 clk = ~clk;

   // {rs, rt, uses_rs, uses_rt, mem_read, rd, redirect, mem_req, mem_ready}
   function automatic logic [20:0] pk(input int rs, input int rt,
                                      input bit urs, input bit urt,
                                      input bit mr, input int rd,
                                      input bit rdr, input bit req,
                                      input bit rdy);
      return {5'(rs), 5'(rt), urs, urt, mr, 5'(rd), rdr, req, rdy};
   endfunction

   function automatic logic [7:0] obs();
      return {hz.pc_freeze, hz.if_id_freeze, hz.if_id_flush, hz.id_ex_freeze,
              hz.id_ex_flush, hz.ex_mem_freeze, hz.mem_wb_flush, hz.halted};
   endfunction

   task automatic apply(input logic [20:0] s);
      {hz.id_rs, hz.id_rt, hz.id_uses_rs, hz.id_uses_rt, hz.ex_mem_read,
       hz.ex_rd, hz.ex_redirect, hz.mem_req, hz.mem_ready} = s;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      apply('0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      apply(pk(5, 0, 1, 0, 1, 5, 0, 1, 0));
      #2;
      checks++;
      if (obs() !== IDLE) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=%b", obs(), IDLE);
      end
      tick();
      rst = 1'b0;
      apply('0);
      #2;
      checks++;
      if (obs() !== IDLE) begin
         failures++;
         $display("FAIL reset_release got=%b exp=%b", obs(), IDLE);
      end
`ifdef HAZARD_STATS_EN
      checks++;
      if ({hz.stall_cycles, hz.flush_events, hz.lu_events} !== 96'd0) begin
         failures++;
         $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0",
                  hz.stall_cycles, hz.flush_events, hz.lu_events);
      end
`endif
      tick();
   endtask

   task automatic test_load_use();
      logic [20:0] st [6];
      logic [7:0]  ex [6];
      st = '{pk(5, 0, 1, 0, 1, 5, 0, 0, 0), pk(5, 0, 1, 0, 0, 5, 0, 0, 0),
             pk(0, 0, 1, 1, 1, 0, 0, 0, 0), pk(3, 9, 0, 1, 1, 9, 0, 0, 0),
             pk(9, 3, 0, 1, 1, 9, 0, 0, 0), pk(7, 7, 1, 1, 1, 8, 0, 0, 0)};
      ex = '{LU, IDLE, IDLE, LU, IDLE, IDLE};
      for (int i = 0; i < 6; i++) begin
         apply(st[i]);
         #2;
         checks++;
         if (obs() !== ex[i]) begin
            failures++;
            $display("FAIL load_use[%0d] got=%b exp=%b", i, obs(), ex[i]);
         end
         tick();
      end
   endtask

   task automatic test_redirect();
      logic [20:0] st [3];
      logic [7:0]  ex [3];
      st = '{pk(5, 0, 1, 0, 1, 5, 1, 0, 0), pk(0, 0, 0, 0, 0, 0, 1, 0, 0),
             pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
      ex = '{RDR, RDR, IDLE};
      for (int i = 0; i < 3; i++) begin
         apply(st[i]);
         #2;
         checks++;
         if (obs() !== ex[i]) begin
            failures++;
            $display("FAIL redirect[%0d] got=%b exp=%b", i, obs(), ex[i]);
         end
         tick();
      end
   endtask

   task automatic test_mem_wait();
      logic [20:0] st [6];
      logic [7:0]  ex [6];
      st = '{pk(0, 0, 0, 0, 0, 0, 0, 1, 0), pk(0, 0, 0, 0, 0, 0, 0, 1, 0),
             pk(0, 0, 0, 0, 0, 0, 0, 1, 0), pk(0, 0, 0, 0, 0, 0, 0, 1, 1),
             pk(0, 0, 0, 0, 0, 0, 0, 1, 1), pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
      ex = '{STALL, STALL, STALL, IDLE, IDLE, IDLE};
      for (int i = 0; i < 6; i++) begin
         apply(st[i]);
         #2;
         checks++;
         if (obs() !== ex[i]) begin
            failures++;
            $display("FAIL mem_wait[%0d] got=%b exp=%b", i, obs(), ex[i]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [20:0] st [7];
      logic [7:0]  ex [7];
      // redirect held through a 2-cycle wait, then load-use held through one
      st = '{pk(0, 0, 0, 0, 0, 0, 1, 1, 0), pk(0, 0, 0, 0, 0, 0, 1, 1, 0),
             pk(0, 0, 0, 0, 0, 0, 1, 1, 1), pk(0, 0, 0, 0, 0, 0, 0, 0, 0),
             pk(4, 0, 1, 0, 1, 4, 0, 1, 0), pk(4, 0, 1, 0, 1, 4, 0, 1, 1),
             pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
      ex = '{STALL, STALL, RDR, IDLE, STALL, LU, IDLE};
      for (int i = 0; i < 7; i++) begin
         apply(st[i]);
         #2;
         checks++;
         if (obs() !== ex[i]) begin
            failures++;
            $display("FAIL back_to_back[%0d] got=%b exp=%b", i, obs(), ex[i]);
         end
         tick();
      end
   endtask

   task automatic test_timeout();
      logic [7:0] ex [8];
      // 1 RUN stall + 4 MEM_WAIT cycles, then HALT held with ready=0 and ready=1
      ex = '{STALL, STALL, STALL, STALL, STALL, HALT, HALT, HALT};
      for (int i = 0; i < 8; i++) begin
         apply(pk(0, 0, 0, 0, 0, 0, 0, 1, (i >= 6) ? 1'b1 : 1'b0));
         #2;
         checks++;
         if (obs() !== ex[i]) begin
            failures++;
            $display("FAIL timeout[%0d] got=%b exp=%b", i, obs(), ex[i]);
         end
         if (i < 7) tick();
      end
      apply(pk(0, 0, 0, 0, 0, 0, 0, 1, 0));
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (obs() !== IDLE) begin
         failures++;
         $display("FAIL timeout_async_rst got=%b exp=%b", obs(), IDLE);
      end
      tick();
      rst = 1'b0;
      apply(pk(0, 0, 0, 0, 0, 0, 0, 1, 1));
      #2;
      checks++;
      if (obs() !== IDLE) begin
         failures++;
         $display("FAIL timeout_after_rst got=%b exp=%b", obs(), IDLE);
      end
      tick();
   endtask

`ifdef HAZARD_STATS_EN
   task automatic test_stats();
      logic [20:0] st [8];
      st = '{pk(5, 0, 1, 0, 1, 5, 0, 0, 0), pk(0, 0, 0, 0, 0, 0, 0, 0, 0),
             pk(0, 0, 0, 0, 0, 0, 0, 1, 0), pk(0, 0, 0, 0, 0, 0, 0, 1, 0),
             pk(0, 0, 0, 0, 0, 0, 0, 1, 0), pk(0, 0, 0, 0, 0, 0, 0, 1, 1),
             pk(0, 0, 0, 0, 0, 0, 1, 0, 0), pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         apply(st[i]);
         tick();
      end
      #1;
      checks++;
      if (hz.stall_cycles !== 32'd4) begin
         failures++;
         $display("FAIL stats_stall got=%0d exp=4", hz.stall_cycles);
      end
      checks++;
      if (hz.lu_events !== 32'd1) begin
         failures++;
         $display("FAIL stats_lu got=%0d exp=1", hz.lu_events);
      end
      checks++;
      if (hz.flush_events !== 32'd1) begin
         failures++;
         $display("FAIL stats_flush got=%0d exp=1", hz.flush_events);
      end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      apply('0);
      #1;
      test_reset();
      test_load_use();
      test_redirect();
      test_mem_wait();
      test_back_to_back();
      test_timeout();
`ifdef HAZARD_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
